micro_sequencer: RTL and testbench

- Next-address stage of the microcoded control unit.
- Holds the control-store address register (CSAR) and drives the control-store ROM, whose output is latched by the microinstruction register.
- Consumes the COND / JUMP_ADDR / RD / WR fields from the microinstruction register, the ALU flags and the instruction register.
- Computes the next microaddress, inserts memory wait states and keeps the condition-code register (PSR).

---
 rtl/micro_sequencer_if.sv | 38 +++
 rtl/micro_sequencer.sv | 139 +++++++++++++
 tb/tb_micro_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Sequencer bundle: microinstruction fields, memory handshake and ALU flags in;
// control-store address, PSR, stall and error out.
interface micro_sequencer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int COND_WIDTH = 3,
  parameter int IR_WIDTH   = 32
);
  logic [COND_WIDTH-1:0] USEQ_COND_IN;
  logic [ADDR_WIDTH-1:0] USEQ_JUMP_ADDR_IN;
  logic                  USEQ_RD_IN;
  logic                  USEQ_WR_IN;
  logic                  USEQ_MEM_READY_IN;
  logic [3:0]            USEQ_ALU_FLAGS_IN;
  logic                  USEQ_FLAGS_LOAD_IN;
  logic [IR_WIDTH-1:0]   USEQ_IR_IN;
  logic [ADDR_WIDTH-1:0] USEQ_CS_ADDR_OUT;
  logic [3:0]            USEQ_PSR_OUT;
  logic                  USEQ_STALL_OUT;
  logic                  USEQ_ERR_OUT;

  modport master (
    output USEQ_COND_IN, USEQ_JUMP_ADDR_IN,
    output USEQ_RD_IN, USEQ_WR_IN,
    output USEQ_MEM_READY_IN, USEQ_ALU_FLAGS_IN,
    output USEQ_FLAGS_LOAD_IN, USEQ_IR_IN,
    input  USEQ_CS_ADDR_OUT, USEQ_PSR_OUT,
    input  USEQ_STALL_OUT, USEQ_ERR_OUT
  );

  modport slave (
    input  USEQ_COND_IN, USEQ_JUMP_ADDR_IN,
    input  USEQ_RD_IN, USEQ_WR_IN,
    input  USEQ_MEM_READY_IN, USEQ_ALU_FLAGS_IN,
    input  USEQ_FLAGS_LOAD_IN, USEQ_IR_IN,
    output USEQ_CS_ADDR_OUT, USEQ_PSR_OUT,
    output USEQ_STALL_OUT, USEQ_ERR_OUT
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microcode next-address stage: CSAR, PSR and memory wait states.
// Define USEQ_MEM_TIMEOUT_EN to trap to TRAP_ADDR on a stuck memory access.
module micro_sequencer #(
  parameter int ADDR_WIDTH     = 11,
  parameter int COND_WIDTH     = 3,
  parameter int IR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 11'h000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = 11'h7FF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic USEQ_CLOCK_50,
  input  logic SC_RegGENERAL_Reset_InLow,
  micro_sequencer_if.slave bus
);

  typedef enum logic {RUN, WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] csar_q, csar_d;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [3:0]            psr_q;
  logic                  stall;
  logic                  take;

  assign stall = SC_RegGENERAL_Reset_InLow
               & (bus.USEQ_RD_IN | bus.USEQ_WR_IN)
               & ~bus.USEQ_MEM_READY_IN;

  // Branches test the registered PSR only.
  always_comb begin
    take = 1'b0;
    unique case (bus.USEQ_COND_IN)
      3'd1:    take = psr_q[3];
      3'd2:    take = psr_q[2];
      3'd3:    take = psr_q[1];
      3'd4:    take = psr_q[0];
      3'd5:    take = bus.USEQ_IR_IN[13];
      3'd6:    take = 1'b1;
      default: take = 1'b0;
    endcase
    if (bus.USEQ_COND_IN == 3'd7)
      next_addr = {1'b1, bus.USEQ_IR_IN[31:30],
                   bus.USEQ_IR_IN[24:19], 2'b00};
    else if (take)
      next_addr = bus.USEQ_JUMP_ADDR_IN;
    else
      next_addr = csar_q + 1'b1;
  end

`ifdef USEQ_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CW > 8) ? CW : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    csar_d  = csar_q;
    cnt_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (stall) state_d = WAIT;
        else       csar_d  = next_addr;
      end
      WAIT: begin
        if (bus.USEQ_MEM_READY_IN) begin
          csar_d  = next_addr;
          state_d = RUN;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          csar_d  = TRAP_ADDR;
          state_d = RUN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge USEQ_CLOCK_50 or negedge SC_RegGENERAL_Reset_InLow) begin
    if (!SC_RegGENERAL_Reset_InLow) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.USEQ_ERR_OUT = err_q;
`else
  always_comb begin
    state_d = state_q;
    csar_d  = csar_q;
    unique case (state_q)
      RUN: begin
        if (stall) state_d = WAIT;
        else       csar_d  = next_addr;
      end
      WAIT: begin
        if (bus.USEQ_MEM_READY_IN) begin
          csar_d  = next_addr;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  logic unused_cfg;
  assign unused_cfg = ^{TRAP_ADDR, TIMEOUT_CYCLES[0]};
  assign bus.USEQ_ERR_OUT = 1'b0;
`endif

  always_ff @(posedge USEQ_CLOCK_50 or negedge SC_RegGENERAL_Reset_InLow) begin
    if (!SC_RegGENERAL_Reset_InLow) begin
      state_q <= RUN;
      csar_q  <= RESET_ADDR;
      psr_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      csar_q  <= csar_d;
      if (bus.USEQ_FLAGS_LOAD_IN && !stall)
        psr_q <= bus.USEQ_ALU_FLAGS_IN;
    end
  end

  logic unused_ir;
  assign unused_ir = ^{bus.USEQ_IR_IN[29:25], bus.USEQ_IR_IN[18:14],
                       bus.USEQ_IR_IN[12:0]};

  assign bus.USEQ_CS_ADDR_OUT = csar_q;
  assign bus.USEQ_PSR_OUT     = psr_q;
  assign bus.USEQ_STALL_OUT   = stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: reset, sequencing, branches,
// decode, wait states and (when enabled) the memory timeout trap.
module tb_micro_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  micro_sequencer_if bus ();

  micro_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .USEQ_CLOCK_50             (clk),
    .SC_RegGENERAL_Reset_InLow (rst_n),
    .bus                       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic jump_to(input logic [10:0] a);
    bus.USEQ_COND_IN      = 3'b110;
    bus.USEQ_JUMP_ADDR_IN = a;
    tick();
  endtask

  initial begin
    bus.USEQ_COND_IN       = 3'b000;
    bus.USEQ_JUMP_ADDR_IN  = 11'h000;
    bus.USEQ_RD_IN         = 1'b0;
    bus.USEQ_WR_IN         = 1'b0;
    bus.USEQ_MEM_READY_IN  = 1'b0;
    bus.USEQ_ALU_FLAGS_IN  = 4'b0000;
    bus.USEQ_FLAGS_LOAD_IN = 1'b0;
    bus.USEQ_IR_IN         = 32'h0;
    tick();
    tick();
    chk("rst_csar", 32'(bus.USEQ_CS_ADDR_OUT), 32'h000);
    chk("rst_psr", 32'(bus.USEQ_PSR_OUT), 32'h0);
    chk("rst_err", 32'(bus.USEQ_ERR_OUT), 32'h0);
    rst_n = 1'b1;

    // reset while waiting
    bus.USEQ_FLAGS_LOAD_IN = 1'b1;
    bus.USEQ_ALU_FLAGS_IN  = 4'b1010;
    jump_to(11'h045);
    chk("psr_load", 32'(bus.USEQ_PSR_OUT), 32'ha);
    bus.USEQ_FLAGS_LOAD_IN = 1'b0;
    bus.USEQ_RD_IN   = 1'b1;
    bus.USEQ_COND_IN = 3'b000;
    tick();
    chk("wait_csar", 32'(bus.USEQ_CS_ADDR_OUT), 32'h045);
    chk("wait_stall", 32'(bus.USEQ_STALL_OUT), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_csar", 32'(bus.USEQ_CS_ADDR_OUT), 32'h000);
    chk("arst_psr", 32'(bus.USEQ_PSR_OUT), 32'h0);
    chk("arst_stall", 32'(bus.USEQ_STALL_OUT), 32'h0);
    chk("arst_err", 32'(bus.USEQ_ERR_OUT), 32'h0);
    bus.USEQ_RD_IN = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst", 32'(bus.USEQ_CS_ADDR_OUT), 32'h001);

    // sequential and wrap
    jump_to(11'h005);
    bus.USEQ_COND_IN = 3'b000;
    tick();
    chk("seq", 32'(bus.USEQ_CS_ADDR_OUT), 32'h006);
    jump_to(11'h7FF);
    bus.USEQ_COND_IN = 3'b000;
    tick();
    chk("wrap", 32'(bus.USEQ_CS_ADDR_OUT), 32'h000);

    // flag branches
    bus.USEQ_FLAGS_LOAD_IN = 1'b1;
    bus.USEQ_ALU_FLAGS_IN  = 4'b1000;
    tick();
    bus.USEQ_FLAGS_LOAD_IN = 1'b0;
    bus.USEQ_COND_IN      = 3'b001;
    bus.USEQ_JUMP_ADDR_IN = 11'h123;
    tick();
    chk("br_n_taken", 32'(bus.USEQ_CS_ADDR_OUT), 32'h123);
    bus.USEQ_FLAGS_LOAD_IN = 1'b1;
    bus.USEQ_ALU_FLAGS_IN  = 4'b0000;
    jump_to(11'h010);
    bus.USEQ_FLAGS_LOAD_IN = 1'b0;
    bus.USEQ_COND_IN = 3'b001;
    tick();
    chk("br_n_fall", 32'(bus.USEQ_CS_ADDR_OUT), 32'h011);
    jump_to(11'h020);
    bus.USEQ_COND_IN       = 3'b010;
    bus.USEQ_JUMP_ADDR_IN  = 11'h300;
    bus.USEQ_FLAGS_LOAD_IN = 1'b1;
    bus.USEQ_ALU_FLAGS_IN  = 4'b0100;
    tick();
    chk("br_z_old", 32'(bus.USEQ_CS_ADDR_OUT), 32'h021);
    chk("psr_z", 32'(bus.USEQ_PSR_OUT), 32'h4);
    bus.USEQ_FLAGS_LOAD_IN = 1'b0;
    tick();
    chk("br_z_new", 32'(bus.USEQ_CS_ADDR_OUT), 32'h300);

    // decode and IR[13] branch
    bus.USEQ_IR_IN   = 32'h8080_0000;
    bus.USEQ_COND_IN = 3'b111;
    tick();
    chk("decode", 32'(bus.USEQ_CS_ADDR_OUT), 32'h640);
    bus.USEQ_IR_IN        = 32'h0000_2000;
    bus.USEQ_COND_IN      = 3'b101;
    bus.USEQ_JUMP_ADDR_IN = 11'h200;
    tick();
    chk("ir13_taken", 32'(bus.USEQ_CS_ADDR_OUT), 32'h200);
    bus.USEQ_IR_IN        = 32'hFFFF_DFFF;
    bus.USEQ_JUMP_ADDR_IN = 11'h100;
    tick();
    chk("ir13_fall", 32'(bus.USEQ_CS_ADDR_OUT), 32'h201);

    // memory wait states
    jump_to(11'h030);
    bus.USEQ_COND_IN       = 3'b000;
    bus.USEQ_RD_IN         = 1'b1;
    bus.USEQ_MEM_READY_IN  = 1'b0;
    bus.USEQ_FLAGS_LOAD_IN = 1'b1;
    bus.USEQ_ALU_FLAGS_IN  = 4'b1111;
    #1;
    chk("stall_run", 32'(bus.USEQ_STALL_OUT), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_csar", 32'(bus.USEQ_CS_ADDR_OUT), 32'h030);
      chk("hold_stall", 32'(bus.USEQ_STALL_OUT), 32'h1);
      chk("hold_psr", 32'(bus.USEQ_PSR_OUT), 32'h4);
    end
    bus.USEQ_MEM_READY_IN = 1'b1;
    #1;
    chk("ready_stall", 32'(bus.USEQ_STALL_OUT), 32'h0);
    tick();
    chk("wait_exit", 32'(bus.USEQ_CS_ADDR_OUT), 32'h031);
    chk("psr_after", 32'(bus.USEQ_PSR_OUT), 32'hf);
    bus.USEQ_FLAGS_LOAD_IN = 1'b0;
    tick();
    chk("ready_same", 32'(bus.USEQ_CS_ADDR_OUT), 32'h032);
    bus.USEQ_WR_IN        = 1'b1;
    bus.USEQ_MEM_READY_IN = 1'b0;
    tick();
    chk("rdwr_hold", 32'(bus.USEQ_CS_ADDR_OUT), 32'h032);
    bus.USEQ_MEM_READY_IN = 1'b1;
    tick();
    chk("rdwr_exit", 32'(bus.USEQ_CS_ADDR_OUT), 32'h033);
    bus.USEQ_RD_IN        = 1'b0;
    bus.USEQ_MEM_READY_IN = 1'b0;

`ifdef USEQ_MEM_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        tick();
        if (bus.USEQ_ERR_OUT === 1'b1) seen = 1'b1;
      end
      chk("to_err", 32'(bus.USEQ_ERR_OUT), 32'h1);
      chk("to_trap", 32'(bus.USEQ_CS_ADDR_OUT), 32'h7ff);
    end
    bus.USEQ_WR_IN = 1'b0;
    tick();
    chk("to_after", 32'(bus.USEQ_CS_ADDR_OUT), 32'h000);
    chk("to_sticky", 32'(bus.USEQ_ERR_OUT), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("to_rst", 32'(bus.USEQ_ERR_OUT), 32'h0);
    rst_n = 1'b1;
`else
    for (int i = 0; i < 8; i++) tick();
    chk("long_hold", 32'(bus.USEQ_CS_ADDR_OUT), 32'h033);
    chk("no_err", 32'(bus.USEQ_ERR_OUT), 32'h0);
    bus.USEQ_MEM_READY_IN = 1'b1;
    tick();
    chk("long_exit", 32'(bus.USEQ_CS_ADDR_OUT), 32'h034);
    bus.USEQ_WR_IN = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
